dmem_responder: RTL and testbench

Data-memory responder for the single-cycle MIPS core's load/store port. It accepts one word request at a time from the core's memory-access side (address, write data, write enable) over a valid/ready handshake. After a programmable number of wait states it returns read data or write acknowledgement, with an error flag for bad addresses. It sits between the datapath's `aluout`/`writedata`/`readdata` signals and on-chip RAM, and lets the core (or a later multicycle core) tolerate memory latency.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the memory-mapped cycle-counter address,
// and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte address of the cycle counter when DMEM_MMIO_EN is defined.
    localparam logic [31:0] MMIO_CYCLE_ADDR = 32'hFFFF_FFFC;

    // Wide enough for LATENCY values 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, synchronous write, registered read.
// Latency: read data appears one edge after i_re; write commits on the i_we edge.
// Backpressure: none; the read register holds its value whenever i_re is low.
//
// Ports: clk; i_we/i_re write/read enables; i_addr word index;
//        i_wdata write data; o_rdata registered read data.
// Contents and the read register are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-outstanding word load/store responder in front of on-chip RAM.
// Latency: request accepted at edge N, response valid from edge N+LATENCY onward.
// Backpressure: req_ready low in WAIT/RESP; RESP holds outputs stable until rsp_ready.
//
// Ports: clk, reset (async, active-low); req_valid/req_ready/req_we/req_addr/req_wdata
//        request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel.
// Optional macro DMEM_MMIO_EN maps MMIO_CYCLE_ADDR to a free-running cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic             r_rd_arr;     // response data comes from the array read register
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_acc_we;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_wdata;
    logic             w_err;
    logic             w_arr_ok;
    logic [31:0]      w_arr_q;

    assign w_accept = (r_state == IDLE) && req_valid;

    // With zero wait states the access happens on the acceptance edge itself.
    assign w_enter_resp = (LATENCY == 0) ? w_accept
                                         : ((r_state == WAIT) && (r_cnt == '0));

    // In IDLE only the zero-latency build accesses memory, straight from the inputs.
    assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

`ifdef DMEM_MMIO_EN
    logic        w_mmio;
    logic [31:0] r_cyc;
    logic [31:0] r_mmio_q;
    logic        r_rd_mmio;

    assign w_mmio   = (w_acc_addr == MMIO_CYCLE_ADDR);
    assign w_err    = ((|w_acc_addr[1:0]) || (w_acc_addr[31:2] >= 30'(DEPTH_WORDS))) && !w_mmio;
    assign w_arr_ok = w_enter_resp && !w_err && !w_mmio;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc     <= '0;
            r_mmio_q  <= '0;
            r_rd_mmio <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_enter_resp) begin
                r_rd_mmio <= w_mmio && !w_acc_we;
                if (w_mmio && !w_acc_we) begin
                    r_mmio_q <= r_cyc;
                end
            end
        end
    end

    assign rsp_rdata = r_rd_mmio ? r_mmio_q : (r_rd_arr ? w_arr_q : '0);
`else
    assign w_err    = (|w_acc_addr[1:0]) || (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_arr_ok = w_enter_resp && !w_err;

    assign rsp_rdata = r_rd_arr ? w_arr_q : '0;
`endif

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_ok && w_acc_we),
        .i_re    (w_arr_ok && !w_acc_we),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_q)
    );

    // Response status is captured on the same edge as the memory access and then
    // held, which keeps it stable for as long as the requester stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_err <= 1'b0;
            r_rd_arr  <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_err <= w_err;
            r_rd_arr  <= w_arr_ok && !w_acc_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (LATENCY=2 and LATENCY=0 instances).
// Latency: expects rsp_valid LATENCY+1 sampled cycles after the acceptance cycle.
// Backpressure: exercises a 5-cycle rsp_ready stall and an ignored request during it.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; returns response data/error and the
    // cycle index of the acceptance edge.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int acc);
        int lat;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd1;
        logic        er, er1;
        int          a1, a2, lat, prev, acc, n;
        logic        zwe   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] zaddr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
        logic [31:0] zwd   [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0, 32'h0};
        logic [31:0] zexp  [4] = '{32'h0, 32'h0, 32'h0000_0100, 32'h0000_0200};

        reset       = 1'b0;
        req_valid   = 1'b0; req_we   = 1'b0; req_addr   = '0; req_wdata   = '0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        reset = 1'b1;

        // Store then load through the 2-wait-state instance.
        do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, rd, er, a1);
        check("st10_err",   32'(er), 32'd0);
        check("st10_rdata", rd, 32'd0);
        do_req("ld10", 1'b0, 32'h10, 32'h0, rd, er, a1);
        check("ld10_rdata", rd, 32'hDEADBEEF);
        check("ld10_err",   32'(er), 32'd0);

        // Highest valid word, then misaligned and out-of-range accesses.
        do_req("stfc", 1'b1, 32'hFC, 32'hCAFE_0001, rd, er, a1);
        do_req("ldfc", 1'b0, 32'hFC, 32'h0, rd, er, a1);
        check("ldfc_rdata", rd, 32'hCAFE_0001);
        check("ldfc_err",   32'(er), 32'd0);
        do_req("ld06", 1'b0, 32'h6, 32'h0, rd, er, a1);
        check("ld06_err",   32'(er), 32'd1);
        check("ld06_rdata", rd, 32'd0);
        do_req("st00", 1'b1, 32'h0, 32'h1111_1111, rd, er, a1);
        do_req("st100", 1'b1, 32'h100, 32'hBAD0_BAD0, rd, er, a1);
        check("st100_err", 32'(er), 32'd1);
        do_req("ld00", 1'b0, 32'h0, 32'h0, rd, er, a1);
        check("ld00_rdata", rd, 32'h1111_1111);
        check("ld00_err",   32'(er), 32'd0);

        // Backpressure: stall RESP for 5 cycles while offering a store.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check("bp_lat", 32'(lat), 32'd3);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_rsp_err",   32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req("bp_ld10", 1'b0, 32'h10, 32'h0, rd, er, a1);
        check("bp_ld10_rdata", rd, 32'hDEADBEEF);

        // Reset in the middle of WAIT for a store must drop it.
        do_req("st20", 1'b1, 32'h20, 32'hA5A5A5A5, rd, er, a1);
        do_req("ld10b", 1'b0, 32'h10, 32'h0, rd, er, a1);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("wait_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        check("wait_req_ready",  32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rw_req_ready", 32'(req_ready), 32'd1);
        check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw_rsp_rdata", rsp_rdata, 32'd0);
        check("rw_rsp_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_req("ld20", 1'b0, 32'h20, 32'h0, rd, er, a1);
        check("ld20_rdata", rd, 32'hA5A5A5A5);

        // Cycle-counter address, accepted 10 cycles apart.
        do_req("mm1", 1'b0, 32'hFFFF_FFFC, 32'h0, rd1, er1, a1);
        while (cyc < a1 + 9) begin
            @(posedge clk);
            #1;
        end
        do_req("mm2", 1'b0, 32'hFFFF_FFFC, 32'h0, rd, er, a2);
`ifdef DMEM_MMIO_EN
        check("mm1_err",  32'(er1), 32'd0);
        check("mm2_err",  32'(er), 32'd0);
        check("mm_delta", rd - rd1, 32'd10);
        do_req("mmst", 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, rd, er, a1);
        check("mmst_err", 32'(er), 32'd0);
`else
        check("mm1_err",   32'(er1), 32'd1);
        check("mm2_err",   32'(er), 32'd1);
        check("mm2_rdata", rd, 32'd0);
        do_req("mmst", 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, rd, er, a1);
        check("mmst_err", 32'(er), 32'd1);
`endif

        // Zero-wait-state instance: back-to-back requests, rsp_ready tied high.
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            z_req_we = zwe[k]; z_req_addr = zaddr[k]; z_req_wdata = zwd[k];
            z_req_valid = 1'b1;
            n = 0;
            while (!z_req_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("z_wait", 32'(n), 32'd0);
            @(posedge clk);
            #1;
            acc = cyc;
            if (k > 0) check("z_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
            @(negedge clk);
            check("z_rsp_valid", 32'(z_rsp_valid), 32'd1);
            check("z_rsp_rdata", z_rsp_rdata, zexp[k]);
            check("z_rsp_err",   32'(z_rsp_err), 32'd0);
            check("z_req_ready", 32'(z_req_ready), 32'd0);
        end
        z_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
